// File: rtl/serializador8p2.sv
// serializador8p2: width down-converter, 8-bit words in, four 2-bit chunks out.
// Holds the word being shifted plus one prefetch word, so back-to-back words
// stream with no idle cycle between them.
//
// Ports:
//   clock          - system clock, all state updates on rising edge
//   reset          - synchronous, active-high reset
//   entrada        - word to serialize
//   entrada_valida - producer has a word on entrada
//   entrada_pronta - block can accept a word this cycle
//   saida          - current 2-bit chunk
//   saida_valida   - saida holds a valid chunk
//   saida_pronta   - consumer accepts the chunk this cycle
//   ultimo         - current chunk is the final chunk of its word
//   ocupado        - a word is in flight or buffered
//
// Parameter MSB_PRIMEIRO: 0 = bits [1:0] first, 1 = bits [7:6] first.
module serializador8p2 #(
    parameter bit MSB_PRIMEIRO = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] entrada,
    input  logic       entrada_valida,
    output logic       entrada_pronta,
    output logic [1:0] saida,
    output logic       saida_valida,
    input  logic       saida_pronta,
    output logic       ultimo,
    output logic       ocupado
);

    localparam int unsigned LARGURA_PALAVRA = 8;
    localparam int unsigned LARGURA_CHUNK   = 2;
    localparam int unsigned LARGURA_CONT    = 2;
    localparam logic [LARGURA_CONT-1:0] CONT_ULTIMO = LARGURA_CONT'(3);

    typedef enum logic {
        OCIOSO,
        ENVIANDO
    } estado_t;

    estado_t                      estado, estado_prox;
    logic [LARGURA_PALAVRA-1:0]   deslocamento, deslocamento_prox;
    logic [LARGURA_CONT-1:0]      contador, contador_prox;
    logic [LARGURA_PALAVRA-1:0]   buffer, buffer_prox;
    logic                         buf_cheio, buf_cheio_prox;

    logic                         aceita;
    logic                         transfere;
    logic                         fim_palavra;
    logic [LARGURA_CONT-1:0]      indice;
    logic [LARGURA_CHUNK-1:0]     chunk;

    // Handshake qualifiers; reset blocks both sides.
    assign entrada_pronta = !reset && !buf_cheio;
    assign saida_valida   = !reset && (estado == ENVIANDO);
    assign aceita         = entrada_valida && entrada_pronta;
    assign transfere      = saida_valida && saida_pronta;
    assign fim_palavra    = transfere && (contador == CONT_ULTIMO);

    // Chunk select: counter maps directly (LSB first) or mirrored (MSB first).
    assign indice = MSB_PRIMEIRO ? (CONT_ULTIMO - contador) : contador;
    assign chunk  = deslocamento[{indice, 1'b0} +: LARGURA_CHUNK];

    assign saida   = saida_valida ? chunk : '0;
    assign ultimo  = saida_valida && (contador == CONT_ULTIMO);
    assign ocupado = !reset && ((estado == ENVIANDO) || buf_cheio);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado       <= OCIOSO;
            deslocamento <= '0;
            contador     <= '0;
            buffer       <= '0;
            buf_cheio    <= 1'b0;
        end else begin
            estado       <= estado_prox;
            deslocamento <= deslocamento_prox;
            contador     <= contador_prox;
            buffer       <= buffer_prox;
            buf_cheio    <= buf_cheio_prox;
        end
    end

    // Next-state logic.
    always_comb begin
        estado_prox       = estado;
        deslocamento_prox = deslocamento;
        contador_prox     = contador;
        buffer_prox       = buffer;
        buf_cheio_prox    = buf_cheio;

        case (estado)
            OCIOSO: begin
                if (aceita) begin
                    deslocamento_prox = entrada;
                    contador_prox     = '0;
                    estado_prox       = ENVIANDO;
                end
            end

            ENVIANDO: begin
                if (fim_palavra) begin
                    // Reload priority: prefetch buffer, then a same-edge word, else idle.
                    contador_prox = '0;
                    if (buf_cheio) begin
                        deslocamento_prox = buffer;
                        if (aceita) begin
                            buffer_prox = entrada;
                        end else begin
                            buf_cheio_prox = 1'b0;
                        end
                    end else if (aceita) begin
                        deslocamento_prox = entrada;
                    end else begin
                        estado_prox = OCIOSO;
                    end
                end else begin
                    if (transfere) begin
                        contador_prox = contador + LARGURA_CONT'(1);
                    end
                    if (aceita) begin
                        buffer_prox    = entrada;
                        buf_cheio_prox = 1'b1;
                    end
                end
            end

            default: estado_prox = OCIOSO;
        endcase
    end

endmodule

// File: tb/tb_serializador8p2.sv
// Directed bench for serializador8p2; runs an LSB-first and an MSB-first
// instance from the same stimulus and checks both.
module tb_serializador8p2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] entrada = 8'h00;
    logic       entrada_valida = 1'b0;
    logic       saida_pronta = 1'b0;

    logic       pronta0, valida0, ultimo0, ocupado0;
    logic [1:0] saida0;
    logic       pronta1, valida1, ultimo1, ocupado1;
    logic [1:0] saida1;

    int passed = 0;
    int total  = 0;
    int xfers  = 0;

    serializador8p2 #(.MSB_PRIMEIRO(1'b0)) dut_lsb (
        .clock(clock), .reset(reset), .entrada(entrada),
        .entrada_valida(entrada_valida), .entrada_pronta(pronta0),
        .saida(saida0), .saida_valida(valida0), .saida_pronta(saida_pronta),
        .ultimo(ultimo0), .ocupado(ocupado0)
    );

    serializador8p2 #(.MSB_PRIMEIRO(1'b1)) dut_msb (
        .clock(clock), .reset(reset), .entrada(entrada),
        .entrada_valida(entrada_valida), .entrada_pronta(pronta1),
        .saida(saida1), .saida_valida(valida1), .saida_pronta(saida_pronta),
        .ultimo(ultimo1), .ocupado(ocupado1)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (valida0 && saida_pronta) xfers <= xfers + 1;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Checks one displayed chunk on both instances.
    task automatic chk_chunk(input string tag, input logic [1:0] e_lsb,
                             input logic [1:0] e_msb, input logic e_ult);
        chk({tag, " valida"}, 8'(valida0), 8'd1);
        chk({tag, " saida_lsb"}, 8'(saida0), 8'(e_lsb));
        chk({tag, " saida_msb"}, 8'(saida1), 8'(e_msb));
        chk({tag, " ultimo"}, 8'(ultimo0), 8'(e_ult));
        chk({tag, " ultimo_msb"}, 8'(ultimo1), 8'(e_ult));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " valida"}, 8'(valida0), 8'd0);
        chk({tag, " valida_msb"}, 8'(valida1), 8'd0);
        chk({tag, " ocupado"}, 8'(ocupado0), 8'd0);
        chk({tag, " ultimo"}, 8'(ultimo0), 8'd0);
    endtask

    logic [1:0] bb_lsb [12] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b00, 2'b11, 2'b11, 2'b00,
                                2'b11, 2'b11, 2'b11, 2'b11};
    logic [1:0] bb_msb [12] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b00, 2'b11, 2'b11, 2'b00,
                                2'b11, 2'b11, 2'b11, 2'b11};
    logic       bb_pronta [12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                   1'b1, 1'b1, 1'b1, 1'b1};
    logic [7:0] palavras [3] = '{8'hA5, 8'h3C, 8'hFF};

    initial begin
        int k;
        int x0;
        logic acc;

        // Reset state
        tick();
        tick();
        chk("rst pronta", 8'(pronta0), 8'd0);
        chk("rst saida", 8'(saida0), 8'd0);
        chk_idle("rst");
        reset = 1'b0;
        #1;
        chk("pos-rst pronta", 8'(pronta0), 8'd1);
        chk_idle("pos-rst");

        // Single word, consumer always ready
        saida_pronta = 1'b1;
        entrada = 8'b11100100;
        entrada_valida = 1'b1;
        tick();
        entrada_valida = 1'b0;
        chk("single ocupado", 8'(ocupado0), 8'd1);
        chk_chunk("single c1", 2'b00, 2'b11, 1'b0);
        tick();
        chk_chunk("single c2", 2'b01, 2'b10, 1'b0);
        tick();
        chk_chunk("single c3", 2'b10, 2'b01, 1'b0);
        tick();
        chk_chunk("single c4", 2'b11, 2'b00, 1'b1);
        tick();
        chk_idle("single end");

        // Backpressure holding the second chunk
        x0 = xfers;
        entrada_valida = 1'b1;
        tick();
        entrada_valida = 1'b0;
        chk_chunk("bp c1", 2'b00, 2'b11, 1'b0);
        tick();
        chk_chunk("bp c2", 2'b01, 2'b10, 1'b0);
        saida_pronta = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_chunk("bp hold", 2'b01, 2'b10, 1'b0);
        end
        saida_pronta = 1'b1;
        tick();
        chk_chunk("bp c3", 2'b10, 2'b01, 1'b0);
        tick();
        chk_chunk("bp c4", 2'b11, 2'b00, 1'b1);
        tick();
        chk_idle("bp end");
        chk("bp transfers", 8'(xfers - x0), 8'd4);

        // Back-to-back words with a producer that keeps offering
        k = 0;
        entrada = palavras[0];
        entrada_valida = 1'b1;
        tick();
        k = 1;
        entrada = palavras[1];
        for (int i = 0; i < 12; i++) begin
            #0;
            chk_chunk("b2b chunk", bb_lsb[i], bb_msb[i], (i % 4) == 3);
            chk("b2b pronta", 8'(pronta0), 8'(bb_pronta[i]));
            acc = entrada_valida && pronta0;
            tick();
            if (acc) begin
                k++;
                if (k < 3) entrada = palavras[k];
                else entrada_valida = 1'b0;
            end
        end
        chk_idle("b2b end");
        chk("b2b all accepted", 8'(k), 8'd3);

        // End of word coincides with a new accept, buffer empty
        entrada = 8'h0F;
        entrada_valida = 1'b1;
        tick();
        entrada_valida = 1'b0;
        chk_chunk("sim c1", 2'b11, 2'b00, 1'b0);
        tick();
        chk_chunk("sim c2", 2'b11, 2'b00, 1'b0);
        tick();
        chk_chunk("sim c3", 2'b00, 2'b11, 1'b0);
        tick();
        chk_chunk("sim c4", 2'b00, 2'b11, 1'b1);
        entrada = 8'hF0;
        entrada_valida = 1'b1;
        tick();
        entrada_valida = 1'b0;
        chk_chunk("sim F0 c1", 2'b00, 2'b11, 1'b0);
        chk("sim buf empty", 8'(pronta0), 8'd1);
        tick();
        chk_chunk("sim F0 c2", 2'b00, 2'b11, 1'b0);
        tick();
        chk_chunk("sim F0 c3", 2'b11, 2'b00, 1'b0);
        tick();
        chk_chunk("sim F0 c4", 2'b11, 2'b00, 1'b1);
        tick();
        chk_idle("sim end");

        // Reset mid-word with a buffered word
        entrada = 8'hA5;
        entrada_valida = 1'b1;
        tick();
        entrada = 8'h3C;
        chk_chunk("rmw c1", 2'b01, 2'b10, 1'b0);
        tick();
        entrada_valida = 1'b0;
        chk_chunk("rmw c2", 2'b01, 2'b10, 1'b0);
        chk("rmw buffered", 8'(pronta0), 8'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("rmw rst saida", 8'(saida0), 8'd0);
        chk("rmw rst pronta", 8'(pronta0), 8'd0);
        chk_idle("rmw rst");
        reset = 1'b0;
        #1;
        chk("rmw rel pronta", 8'(pronta0), 8'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle("rmw after");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
